// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-path constants, entry/tag types and a helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR         = 32'h00000013;
    localparam logic [XLEN-1:0] BASE_ADDR_DEFAULT = 32'h01000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // In-flight request tag: the epoch at issue time and the requested PC.
    typedef struct packed {
        logic            epoch;
        logic [XLEN-1:0] pc;
    } fetch_tag_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Synchronous FIFO with flush, occupancy count and registered head.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A push into a full FIFO is only legal when a pop frees a slot.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Sequential prefetching fetch stage with redirect flush and stall.
//            Define FETCH_BUFFER_STATS_EN to add flush/bubble/discard counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int              DATAW           = XLEN,
    parameter logic [DATAW-1:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [DATAW-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [DATAW-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [DATAW-1:0] redirect_pc,
    input  logic             stall,
    output logic             out_valid,
    output logic [DATAW-1:0] out_instr,
    output logic [DATAW-1:0] out_pc
`ifdef FETCH_BUFFER_STATS_EN
    ,
    output logic [31:0]      stat_flushes,
    output logic [31:0]      stat_bubbles,
    output logic [31:0]      stat_discards
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [DATAW-1:0] fetch_pc_q, fetch_pc_d;
    logic             epoch_q, epoch_d;

    fetch_entry_t     entry_in, head_entry;
    fetch_tag_t       tag_in, tag_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic [OW-1:0]    outstanding;
    logic             tag_full, tag_empty;
    logic [SW-1:0]    credit_used;
    logic             rsp_fresh, rsp_stale, out_pop;

    always_comb begin
        // Credit is reserved at issue, so every accepted response has a slot.
        credit_used = SW'(fifo_count) + SW'(outstanding);
        imem_req    = !reset && !redirect_valid && !fifo_full && !tag_full
                      && (credit_used < SW'(DEPTH));
        imem_addr   = fetch_pc_q;

        // A response with no tag belongs to a request issued before reset.
        rsp_fresh   = imem_rvalid && !tag_empty && (tag_head.epoch == epoch_q)
                      && !redirect_valid;
        rsp_stale   = imem_rvalid && !rsp_fresh;

        out_valid   = !fifo_empty;
        out_instr   = out_valid ? head_entry.instr : NOP_INSTR;
        out_pc      = out_valid ? head_entry.pc : '0;
        out_pop     = out_valid && !stall && !redirect_valid;

        entry_in    = '{pc: tag_head.pc, instr: imem_rdata};
        tag_in      = '{epoch: epoch_q, pc: fetch_pc_q};

        fetch_pc_d  = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + DATAW'(4);
        end
        epoch_d = epoch_q ^ redirect_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= BASE_ADDR;
            epoch_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clock     (clock),
        .reset     (reset),
        .push      (rsp_fresh),
        .push_data (entry_in),
        .pop       (out_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // Tags are never flushed: stale responses must still retire their slot.
    sync_fifo #(
        .WIDTH ($bits(fetch_tag_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clock     (clock),
        .reset     (reset),
        .push      (imem_req),
        .push_data (tag_in),
        .pop       (imem_rvalid),
        .flush     (1'b0),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (tag_head)
    );

`ifdef FETCH_BUFFER_STATS_EN
    logic [31:0] stat_flushes_q, stat_flushes_d;
    logic [31:0] stat_bubbles_q, stat_bubbles_d;
    logic [31:0] stat_discards_q, stat_discards_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        stat_flushes_d  = sat_inc(stat_flushes_q, redirect_valid);
        stat_bubbles_d  = sat_inc(stat_bubbles_q, !out_valid && !stall);
        stat_discards_d = sat_inc(stat_discards_q, rsp_stale);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flushes_q  <= '0;
            stat_bubbles_q  <= '0;
            stat_discards_q <= '0;
        end else begin
            stat_flushes_q  <= stat_flushes_d;
            stat_bubbles_q  <= stat_bubbles_d;
            stat_discards_q <= stat_discards_d;
        end
    end

    assign stat_flushes  = stat_flushes_q;
    assign stat_bubbles  = stat_bubbles_q;
    assign stat_discards = stat_discards_q;
`else
    logic unused_stale;
    assign unused_stale = rsp_stale;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Directed vector bench for fetch_buffer with an in-order memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_buffer;
    import cpu_pkg::*;

    localparam logic [31:0] BASE = 32'h01000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_BUFFER_STATS_EN
    logic [31:0] stat_flushes, stat_bubbles, stat_discards;
`endif

    fetch_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_BUFFER_STATS_EN
        ,
        .stat_flushes   (stat_flushes),
        .stat_bubbles   (stat_bubbles),
        .stat_discards  (stat_discards)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    typedef struct packed {
        logic        st;
        logic        ov;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mkv(input logic st, input logic ov, input logic [31:0] pc,
                                 input logic req, input logic [31:0] addr);
        vec_t v;
        v.st = st; v.ov = ov; v.pc = pc; v.req = req; v.addr = addr;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, serve memory, check outputs, capture request.
    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic eov, input logic [31:0] epc,
                        input logic ereq, input logic [31:0] eaddr);
        @(negedge clock);
        cyc++;
        reset          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, eov});
        chk("out_pc", out_pc, eov ? epc : 32'h0);
        chk("out_instr", out_instr, eov ? instr_of(epc) : NOP_INSTR);
        chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
        if (ereq) chk("imem_addr", imem_addr, eaddr);
        if (imem_req === 1'b1) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
        end
    endtask

    // System reset of DUT and memory model together; first reset cycle unchecked.
    task automatic hard_reset(input int new_lat);
        @(negedge clock);
        cyc++;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        lat = new_lat;
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        // Free run, then 6-cycle stall filling the FIFO, then release.
        vecs[0]  = mkv(0, 0, 32'h00, 1, 32'h00);
        vecs[1]  = mkv(0, 0, 32'h00, 1, 32'h04);
        vecs[2]  = mkv(0, 1, 32'h00, 1, 32'h08);
        vecs[3]  = mkv(0, 1, 32'h04, 1, 32'h0C);
        vecs[4]  = mkv(0, 1, 32'h08, 1, 32'h10);
        vecs[5]  = mkv(0, 1, 32'h0C, 1, 32'h14);
        vecs[6]  = mkv(1, 1, 32'h10, 1, 32'h18);
        vecs[7]  = mkv(1, 1, 32'h10, 1, 32'h1C);
        vecs[8]  = mkv(1, 1, 32'h10, 0, 32'h00);
        vecs[9]  = mkv(1, 1, 32'h10, 0, 32'h00);
        vecs[10] = mkv(1, 1, 32'h10, 0, 32'h00);
        vecs[11] = mkv(1, 1, 32'h10, 0, 32'h00);
        vecs[12] = mkv(0, 1, 32'h10, 0, 32'h00);
        vecs[13] = mkv(0, 1, 32'h14, 1, 32'h20);
        vecs[14] = mkv(0, 1, 32'h18, 1, 32'h24);
        vecs[15] = mkv(0, 1, 32'h1C, 1, 32'h28);
        vecs[16] = mkv(0, 1, 32'h20, 1, 32'h2C);
        vecs[17] = mkv(0, 1, 32'h24, 1, 32'h30);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step(0, vecs[i].st, 0, 0, vecs[i].ov, BASE + vecs[i].pc,
                 vecs[i].req, BASE + vecs[i].addr);
        end

        // Redirect with two requests in flight (3-cycle memory).
        hard_reset(3);
        r = 32'h01000100;
        step(0, 0, 0, 0, 0, 0,        1, BASE);
        step(0, 0, 0, 0, 0, 0,        1, BASE + 4);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 1, BASE,     1, BASE + 8);
        step(0, 0, 0, 0, 1, BASE + 4, 1, BASE + 12);
        step(0, 0, 1, r, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        1, r);
        step(0, 0, 0, 0, 0, 0,        1, r + 4);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 1, r,        1, r + 8);
        step(0, 0, 0, 0, 1, r + 4,    1, r + 12);

        // Full FIFO, redirect+stall together (misaligned target), then PC wrap.
        hard_reset(1);
        step(0, 1, 0, 0, 0, 0,    1, BASE);
        step(0, 1, 0, 0, 0, 0,    1, BASE + 4);
        step(0, 1, 0, 0, 1, BASE, 1, BASE + 8);
        step(0, 1, 0, 0, 1, BASE, 1, BASE + 12);
        step(0, 1, 0, 0, 1, BASE, 0, 0);
        step(0, 1, 0, 0, 1, BASE, 0, 0);
        step(0, 1, 1, 32'h02000006, 1, BASE, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 32'h02000004);
        step(0, 0, 0, 0, 0, 0, 1, 32'h02000008);
        step(0, 0, 1, 32'hFFFFFFF8, 1, 32'h02000004, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFF8);
        step(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
        step(0, 0, 0, 0, 1, 32'hFFFFFFF8, 1, 32'h00000000);
        step(0, 0, 0, 0, 1, 32'hFFFFFFFC, 1, 32'h00000004);
        step(0, 0, 0, 0, 1, 32'h00000000, 1, 32'h00000008);

        // Reset with two requests outstanding; memory keeps answering.
        hard_reset(3);
        step(0, 0, 0, 0, 0, 0,        1, BASE);
        step(0, 0, 0, 0, 0, 0,        1, BASE + 4);
        step(1, 0, 0, 0, 0, 0,        0, 0);
        step(1, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        1, BASE);
        step(0, 0, 0, 0, 0, 0,        1, BASE + 4);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 0, 0,        0, 0);
        step(0, 0, 0, 0, 1, BASE,     1, BASE + 8);
        step(0, 0, 0, 0, 1, BASE + 4, 1, BASE + 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
